// File: rtl/camera_sensor_emulator.sv
// Parallel camera sensor emulator: frame/line timing plus Bayer test patterns.
// Stands in for the physical sensor during capture-path bring-up.
module camera_sensor_emulator #(
    parameter int ACTIVE_W    = 640,
    parameter int ACTIVE_H    = 480,
    parameter int H_BLANK     = 160,
    parameter int V_BLANK     = 45,
    parameter int FV_LV_SETUP = 2,
    parameter int LV_FV_HOLD  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cam_reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] const_value,
    output logic        frame_valid,
    output logic        line_valid,
    output logic [11:0] data_out,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int BAR_W = ACTIVE_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_BLANK,
        S_HOLD,
        S_VBLANK
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] row, row_n;
    logic [15:0] bar_pos, bar_pos_n;
    logic [2:0]  bar_idx, bar_idx_n;
    logic [11:0] pcnt, pcnt_n;
    logic [1:0]  pat_q, pat_n;
    logic [11:0] const_q, const_n;
    logic        start;
    logic        fv_n, lv_n, done_n;
    logic [2:0]  mask;
    logic [1:0]  chan;
    logic [11:0] pix_n;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        row_n     = row;
        pcnt_n    = pcnt;
        pat_n     = pat_q;
        const_n   = const_q;
        bar_pos_n = bar_pos;
        bar_idx_n = bar_idx;
        start     = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                start = enable;
            end
            S_SETUP: begin
                if (cnt == 16'(FV_LV_SETUP - 1)) begin
                    state_n = S_ACTIVE;
                    cnt_n   = '0;
                end
            end
            S_ACTIVE: begin
                pcnt_n = pcnt + 12'd1;
                if (cnt == 16'(ACTIVE_W - 1)) begin
                    cnt_n   = '0;
                    state_n = (row == 16'(ACTIVE_H - 1)) ? S_HOLD : S_BLANK;
                end
            end
            S_BLANK: begin
                if (cnt == 16'(H_BLANK - 1)) begin
                    state_n = S_ACTIVE;
                    cnt_n   = '0;
                    row_n   = row + 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt == 16'(LV_FV_HOLD - 1)) begin
                    state_n = S_VBLANK;
                    cnt_n   = '0;
                end
            end
            S_VBLANK: begin
                if (cnt == 16'(V_BLANK - 1)) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                    start   = enable;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (start) begin
            state_n = S_SETUP;
            cnt_n   = '0;
            row_n   = '0;
            pcnt_n  = '0;
            pat_n   = pattern_sel;
            const_n = const_value;
        end
        // bar position tracks the pixel presented after this edge
        if (state_n == S_ACTIVE) begin
            if (state != S_ACTIVE) begin
                bar_pos_n = '0;
                bar_idx_n = '0;
            end else if (bar_pos == 16'(BAR_W - 1)) begin
                bar_pos_n = '0;
                bar_idx_n = bar_idx + 3'd1;
            end else begin
                bar_pos_n = bar_pos + 16'd1;
            end
        end
    end

    always_comb begin
        fv_n   = (state_n == S_SETUP) || (state_n == S_ACTIVE) ||
                 (state_n == S_BLANK) || (state_n == S_HOLD);
        lv_n   = (state_n == S_ACTIVE);
        done_n = (state_n == S_HOLD) && (cnt_n == 16'(LV_FV_HOLD - 1));
        mask   = 3'd7 - bar_idx_n;
        unique case ({row_n[0], cnt_n[0]})
            2'b01:   chan = 2'd2;
            2'b10:   chan = 2'd0;
            default: chan = 2'd1;
        endcase
        unique case (pat_n)
            2'd0:    pix_n = {12{mask[chan]}};
            2'd1:    pix_n = pcnt_n;
            2'd2:    pix_n = const_n;
            default: pix_n = {12{cnt_n[3] ^ row_n[3]}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !cam_reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            row         <= '0;
            pcnt        <= '0;
            pat_q       <= '0;
            const_q     <= '0;
            bar_pos     <= '0;
            bar_idx     <= '0;
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            data_out    <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            row         <= row_n;
            pcnt        <= pcnt_n;
            pat_q       <= pat_n;
            const_q     <= const_n;
            bar_pos     <= bar_pos_n;
            bar_idx     <= bar_idx_n;
            frame_valid <= fv_n;
            line_valid  <= lv_n;
            data_out    <= lv_n ? pix_n : 12'd0;
            frame_done  <= done_n;
            frame_count <= frame_count + {15'd0, done_n};
        end
    end

endmodule

// File: tb/tb_camera_sensor_emulator.sv
// Bench for camera_sensor_emulator: frame-level queue model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_camera_sensor_emulator;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int HB = 2;
    localparam int VB = 3;
    localparam int SU = 2;
    localparam int HO = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cam_reset_n = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd1;
    logic [11:0] const_value = 12'd0;
    logic        frame_valid;
    logic        line_valid;
    logic [11:0] data_out;
    logic        frame_done;
    logic [15:0] frame_count;

    camera_sensor_emulator #(
        .ACTIVE_W(W), .ACTIVE_H(H), .H_BLANK(HB), .V_BLANK(VB),
        .FV_LV_SETUP(SU), .LV_FV_HOLD(HO)
    ) dut (
        .clk(clk), .reset(reset), .cam_reset_n(cam_reset_n),
        .enable(enable), .pattern_sel(pattern_sel),
        .const_value(const_value), .frame_valid(frame_valid),
        .line_valid(line_valid), .data_out(data_out),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        fv;
        logic        lv;
        logic [11:0] d;
        logic        done;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_count;

    function automatic logic [11:0] pix(input int p, input int r,
                                        input int c, input logic [11:0] k);
        int bar, mask, bitn;
        case (p)
            0: begin
                bar  = c / (W / 8);
                mask = 7 - bar;
                if (r % 2 == 0) bitn = (c % 2 == 0) ? 1 : 2;
                else            bitn = (c % 2 == 0) ? 0 : 1;
                return ((mask >> bitn) & 1) != 0 ? 12'hFFF : 12'h000;
            end
            1: return 12'((r * W + c) % 4096);
            2: return k;
            default: return (((c >> 3) ^ (r >> 3)) & 1) != 0 ? 12'hFFF : 12'h000;
        endcase
    endfunction

    function automatic void push(input logic fv, input logic lv,
                                 input logic [11:0] d, input logic dn);
        exp_t x;
        x.fv = fv; x.lv = lv; x.d = d; x.done = dn;
        q.push_back(x);
    endfunction

    function automatic void build_frame(input int p, input logic [11:0] k);
        for (int i = 0; i < SU; i++) push(1, 0, 0, 0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) push(1, 1, pix(p, r, c, k), 0);
            if (r < H - 1)
                for (int i = 0; i < HB; i++) push(1, 0, 0, 0);
        end
        for (int i = 0; i < HO; i++) push(1, 0, 0, (i == HO - 1) ? 1'b1 : 1'b0);
        for (int i = 0; i < VB; i++) push(0, 0, 0, 0);
    endfunction

    logic [11:0] pix_obs[H][W];
    int          fv_len = 0, last_fv_len = 0, gap = 0, last_gap = 0;
    int          lv_pulses = 0, col_i = 0;
    logic        pfv = 1'b0, plv = 1'b0;

    initial begin
        exp_t e;
        exp_t z;
        z.fv = 0; z.lv = 0; z.d = 0; z.done = 0;
        e = z;
        m_count = 0;
        forever begin
            @(posedge clk);
            if (reset || !cam_reset_n) begin
                q.delete();
                m_count = 0;
                e = z;
            end else begin
                if (q.size() == 0 && enable) build_frame(int'(pattern_sel), const_value);
                if (q.size() > 0) e = q.pop_front();
                else e = z;
                if (e.done) m_count++;
            end
            @(negedge clk);
            chk("m_fv", {31'd0, frame_valid}, {31'd0, e.fv});
            chk("m_lv", {31'd0, line_valid}, {31'd0, e.lv});
            chk("m_data", {20'd0, data_out}, {20'd0, e.d});
            chk("m_done", {31'd0, frame_done}, {31'd0, e.done});
            chk("m_count", {16'd0, frame_count}, {16'd0, m_count});
            if (frame_valid && !pfv) begin
                last_gap = gap;
                fv_len = 0;
                lv_pulses = 0;
            end
            if (!frame_valid && pfv) begin
                last_fv_len = fv_len;
                gap = 0;
            end
            if (frame_valid) fv_len++;
            else gap++;
            if (line_valid && !plv) begin
                lv_pulses++;
                col_i = 0;
            end
            if (line_valid) begin
                if (lv_pulses >= 1 && lv_pulses <= H && col_i < W)
                    pix_obs[lv_pulses-1][col_i] = data_out;
                col_i++;
            end
            pfv = frame_valid;
            plv = line_valid;
        end
    end

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got timeout expected frame_done");
        end
    endtask

    task automatic wait_cond_lv(input int row_need, input int lim);
        int n;
        n = 0;
        while (!(line_valid === 1'b1 && (row_need < 0 || lv_pulses == row_need))
               && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) begin
            checks++;
            errors++;
            $display("FAIL wait_lv: got timeout expected line_valid");
        end
    endtask

    task automatic check_counter_frame(input string tag);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                chk($sformatf("%s_px_r%0d_c%0d", tag, r, c),
                    {20'd0, pix_obs[r][c]}, 32'(r * W + c));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_fv", {31'd0, frame_valid}, 0);
        chk("rst_data", {20'd0, data_out}, 0);
        chk("rst_count", {16'd0, frame_count}, 0);
        reset = 1'b0;
        @(negedge clk);

        pattern_sel = 2'd1;
        enable = 1'b1;
        @(negedge clk);
        chk("t1_fv_rise", {31'd0, frame_valid}, 1);
        chk("t1_lv_setup0", {31'd0, line_valid}, 0);
        @(negedge clk);
        chk("t1_lv_setup1", {31'd0, line_valid}, 0);
        @(negedge clk);
        chk("t1_lv_first", {31'd0, line_valid}, 1);
        chk("t1_data_first", {20'd0, data_out}, 0);
        wait_done(200);
        repeat (2) @(negedge clk);
        chk("t1_count", {16'd0, frame_count}, 1);
        chk("t1_fv_len", 32'(last_fv_len), 41);
        chk("t1_lv_pulses", 32'(lv_pulses), 4);
        check_counter_frame("t1");

        wait_done(200);
        wait_done(200);
        pattern_sel = 2'd0;
        repeat (2) @(negedge clk);
        chk("t2_count", {16'd0, frame_count}, 3);
        chk("t2_gap", 32'(last_gap), 3);
        chk("t2_lv_pulses", 32'(lv_pulses), 4);
        chk("t2_fv_len", 32'(last_fv_len), 41);

        wait_done(200);
        pattern_sel = 2'd2;
        const_value = 12'hA5C;
        chk("t3_r0c0", {20'd0, pix_obs[0][0]}, 32'hFFF);
        chk("t3_r0c3", {20'd0, pix_obs[0][3]}, 32'hFFF);
        chk("t3_r1c3", {20'd0, pix_obs[1][3]}, 32'h000);
        chk("t3_r1c2", {20'd0, pix_obs[1][2]}, 32'hFFF);
        chk("t3_r0c7", {20'd0, pix_obs[0][7]}, 32'h000);
        chk("t3_r3c7", {20'd0, pix_obs[3][7]}, 32'h000);

        n = 0;
        while (frame_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        pattern_sel = 2'd3;
        wait_done(200);
        repeat (2) @(negedge clk);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                chk($sformatf("t4_const_r%0d_c%0d", r, c),
                    {20'd0, pix_obs[r][c]}, 32'hA5C);
        wait_done(200);
        repeat (2) @(negedge clk);
        chk("t4_checker_r0c0", {20'd0, pix_obs[0][0]}, 0);
        chk("t4_checker_r3c7", {20'd0, pix_obs[3][7]}, 0);

        wait_cond_lv(3, 200);
        enable = 1'b0;
        wait_done(200);
        repeat (2) @(negedge clk);
        chk("t5_fv_len", 32'(last_fv_len), 41);
        chk("t5_count", {16'd0, frame_count}, 7);
        repeat (12) @(negedge clk);
        chk("t5_idle_fv", {31'd0, frame_valid}, 0);
        chk("t5_idle_lv", {31'd0, line_valid}, 0);
        chk("t5_idle_data", {20'd0, data_out}, 0);
        chk("t5_idle_count", {16'd0, frame_count}, 7);

        pattern_sel = 2'd1;
        enable = 1'b1;
        wait_cond_lv(-1, 100);
        repeat (3) @(negedge clk);
        cam_reset_n = 1'b0;
        @(negedge clk);
        chk("t6_fv", {31'd0, frame_valid}, 0);
        chk("t6_lv", {31'd0, line_valid}, 0);
        chk("t6_data", {20'd0, data_out}, 0);
        chk("t6_done", {31'd0, frame_done}, 0);
        chk("t6_count", {16'd0, frame_count}, 0);
        cam_reset_n = 1'b1;
        wait_done(200);
        repeat (2) @(negedge clk);
        chk("t6_count_after", {16'd0, frame_count}, 1);
        check_counter_frame("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

endmodule
